// File: rtl/ddc_fir_pkg.sv
// ddc_fir_pkg: shared constants and FSM states for the DDC 15-tap symmetric FIR.
// Consumed by ddc_sym_fir15 and its per-channel datapath ddc_fir_mac.
package ddc_fir_pkg;

    localparam int NUM_TAPS       = 15;
    localparam int NUM_UNIQUE     = 8;
    localparam int CENTER_IDX     = 7;
    localparam int COEF_FRAC_BITS = 15;
    localparam int ROUND_CONST    = 2 ** (COEF_FRAC_BITS - 1);

    // Eight products of IN+COEF+1 bits; three guard bits keep the sum from wrapping
    function automatic int accWidth(input int inWidth, input int coefWidth);
        return inWidth + coefWidth + 4;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND
    } firState_t;

endpackage

// File: rtl/ddc_fir_mac.sv
// ddc_fir_mac: one channel of pre-add, multiply, accumulate and round/saturate.
// Sequencing (tap selection, clear, enable) is owned by the parent.
module ddc_fir_mac
    import ddc_fir_pkg::*;
#(
    parameter int IN_WIDTH   = 18,
    parameter int COEF_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         accEn,
    input  logic signed [IN_WIDTH-1:0]   tapA,
    input  logic signed [IN_WIDTH-1:0]   tapB,
    input  logic signed [COEF_WIDTH-1:0] coef,
    output logic signed [IN_WIDTH-1:0]   result
);

    localparam int PROD_WIDTH = IN_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_WIDTH  = accWidth(IN_WIDTH, COEF_WIDTH);

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        (ACC_WIDTH + 1)'((2 ** (IN_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic signed [IN_WIDTH:0]     preAdd;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH:0]    rounded;
    logic signed [ACC_WIDTH:0]    scaled;

    // Fold the symmetric tap pair, then one multiply per clock
    always_comb begin
        preAdd  = (IN_WIDTH + 1)'(tapA) + (IN_WIDTH + 1)'(tapB);
        product = PROD_WIDTH'(preAdd) * PROD_WIDTH'(coef);
    end

    // Cleared when a sample is accepted, one tap pair added per MAC cycle
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (accEn) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

    // Round half up, drop the Q1.15 fraction, clamp to the sample range
    always_comb begin
        rounded = (ACC_WIDTH + 1)'(acc) + (ACC_WIDTH + 1)'(ROUND_CONST);
        scaled  = rounded >>> COEF_FRAC_BITS;
        if (scaled > SAT_MAX) begin
            result = SAT_MAX[IN_WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            result = SAT_MIN[IN_WIDTH-1:0];
        end else begin
            result = scaled[IN_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ddc_sym_fir15.sv
// ddc_sym_fir15: I/Q 15-tap symmetric FIR, one time-multiplexed MAC per channel.
// Define DDC_FIR_BYPASS_EN to add a bypass port that outputs the centre tap.
module ddc_sym_fir15
    import ddc_fir_pkg::*;
#(
    parameter int IN_WIDTH   = 18,
    parameter int COEF_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clkEn,
`ifdef DDC_FIR_BYPASS_EN
    input  logic                         bypass,
`endif
    input  logic signed [IN_WIDTH-1:0]   iIn,
    input  logic signed [IN_WIDTH-1:0]   qIn,
    input  logic signed [COEF_WIDTH-1:0] c0,
    input  logic signed [COEF_WIDTH-1:0] c1,
    input  logic signed [COEF_WIDTH-1:0] c2,
    input  logic signed [COEF_WIDTH-1:0] c3,
    input  logic signed [COEF_WIDTH-1:0] c4,
    input  logic signed [COEF_WIDTH-1:0] c5,
    input  logic signed [COEF_WIDTH-1:0] c6,
    input  logic signed [COEF_WIDTH-1:0] c7,
    output logic signed [IN_WIDTH-1:0]   iOut,
    output logic signed [IN_WIDTH-1:0]   qOut,
    output logic                         outEn,
    output logic                         busy,
    output logic                         overrun
);

    typedef logic signed [IN_WIDTH-1:0] sample_t;

    firState_t state;
    firState_t stateNext;

    logic [2:0] idx;
    logic [3:0] nearIdx;
    logic [3:0] mirrorIdx;
    logic       accept;
    logic       lastTap;
    logic       bypassSel;

    sample_t xI [NUM_TAPS];
    sample_t xQ [NUM_TAPS];

    logic signed [COEF_WIDTH-1:0] coefR [NUM_UNIQUE];

    sample_t tapBI;
    sample_t tapBQ;
    sample_t macI;
    sample_t macQ;

    assign accept    = clkEn && (state == IDLE);
    assign busy      = (state != IDLE);
    assign lastTap   = (idx == 3'(CENTER_IDX));
    assign nearIdx   = {1'b0, idx};
    assign mirrorIdx = 4'(NUM_TAPS - 1) - nearIdx;

    // The centre tap has no mirror partner, so its pre-add input is zero
    assign tapBI = lastTap ? '0 : xI[mirrorIdx];
    assign tapBQ = lastTap ? '0 : xQ[mirrorIdx];

`ifdef DDC_FIR_BYPASS_EN
    logic bypassR;

    // Bypass choice travels with the sample it was accepted alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            bypassR <= 1'b0;
        end else if (accept) begin
            bypassR <= bypass;
        end
    end

    assign bypassSel = bypassR;
`else
    assign bypassSel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: accept, walk the eight unique taps, then round
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (clkEn) stateNext = MAC;
            MAC:     if (lastTap) stateNext = ROUND;
            ROUND:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Delay lines and coefficient snapshot move only on an accepted sample
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                xI[k] <= '0;
                xQ[k] <= '0;
            end
            for (int k = 0; k < NUM_UNIQUE; k++) begin
                coefR[k] <= '0;
            end
        end else if (accept) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) begin
                xI[k] <= xI[k-1];
                xQ[k] <= xQ[k-1];
            end
            xI[0]    <= iIn;
            xQ[0]    <= qIn;
            coefR[0] <= c0;
            coefR[1] <= c1;
            coefR[2] <= c2;
            coefR[3] <= c3;
            coefR[4] <= c4;
            coefR[5] <= c5;
            coefR[6] <= c6;
            coefR[7] <= c7;
        end
    end

    // Tap counter, output registers, one-cycle outEn and sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            iOut    <= '0;
            qOut    <= '0;
            outEn   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            outEn <= 1'b0;
            if (accept) begin
                idx <= '0;
            end else if (state == MAC) begin
                idx <= idx + 3'd1;
            end
            if (clkEn && busy) begin
                overrun <= 1'b1;
            end
            if (state == ROUND) begin
                iOut  <= bypassSel ? xI[CENTER_IDX] : macI;
                qOut  <= bypassSel ? xQ[CENTER_IDX] : macQ;
                outEn <= 1'b1;
            end
        end
    end

    ddc_fir_mac #(
        .IN_WIDTH   (IN_WIDTH),
        .COEF_WIDTH (COEF_WIDTH)
    ) uMacI (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .accEn  (state == MAC),
        .tapA   (xI[nearIdx]),
        .tapB   (tapBI),
        .coef   (coefR[idx]),
        .result (macI)
    );

    ddc_fir_mac #(
        .IN_WIDTH   (IN_WIDTH),
        .COEF_WIDTH (COEF_WIDTH)
    ) uMacQ (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .accEn  (state == MAC),
        .tapA   (xQ[nearIdx]),
        .tapB   (tapBQ),
        .coef   (coefR[idx]),
        .result (macQ)
    );

endmodule

// File: tb/tb_ddc_sym_fir15.sv
// tb_ddc_sym_fir15: directed self-checking bench for ddc_sym_fir15.
// Expected values are hand-derived from the coefficient set and Q1.15 rounding.
module tb_ddc_sym_fir15;

    localparam int W  = 18;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic clkEn = 1'b0;
`ifdef DDC_FIR_BYPASS_EN
    logic bypass = 1'b0;
`endif
    logic signed [W-1:0]  iIn = '0;
    logic signed [W-1:0]  qIn = '0;
    logic signed [CW-1:0] coef [8];
    logic signed [W-1:0]  iOut;
    logic signed [W-1:0]  qOut;
    logic outEn;
    logic busy;
    logic overrun;

    int checks = 0;
    int errors = 0;

    int impC [8]  = '{49, 157, -216, -1186, -868, 3067, 9221, 12311};
    int impR [16] = '{49, 157, -216, -1186, -868, 3067, 9221, 12311,
                      9221, 3067, -868, -1186, -216, 157, 49, 0};

    always #5 clk = ~clk;

    ddc_sym_fir15 #(
        .IN_WIDTH   (W),
        .COEF_WIDTH (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clkEn   (clkEn),
`ifdef DDC_FIR_BYPASS_EN
        .bypass  (bypass),
`endif
        .iIn     (iIn),
        .qIn     (qIn),
        .c0      (coef[0]),
        .c1      (coef[1]),
        .c2      (coef[2]),
        .c3      (coef[3]),
        .c4      (coef[4]),
        .c5      (coef[5]),
        .c6      (coef[6]),
        .c7      (coef[7]),
        .iOut    (iOut),
        .qOut    (qOut),
        .outEn   (outEn),
        .busy    (busy),
        .overrun (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clkEn = 1'b0;
        iIn   = '0;
        qIn   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic setImpulseCoefs();
        for (int k = 0; k < 8; k++) coef[k] = 16'(impC[k]);
    endtask

    // Pulses one sample and returns in the cycle where outEn is high
    task automatic sendSample(input int i, input int q, output int lat,
                              output int oi, output int oq);
        iIn   = 18'(i);
        qIn   = 18'(q);
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        iIn   = '0;
        qIn   = '0;
        lat   = 1;
        while (outEn !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        oi = int'(iOut);
        oq = int'(qOut);
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (iOut !== 18'sd0) begin
            errors++;
            $display("FAIL reset_iOut: got %0d expected 0", iOut);
        end
        checks++;
        if (qOut !== 18'sd0) begin
            errors++;
            $display("FAIL reset_qOut: got %0d expected 0", qOut);
        end
        checks++;
        if (outEn !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: outEn=%b busy=%b overrun=%b expected 0 0 0",
                     outEn, busy, overrun);
        end
    endtask

    task automatic test_latency();
        logic expBusy;
        logic expOut;
        doReset();
        setImpulseCoefs();
        iIn   = 18'sd1000;
        clkEn = 1'b1;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            expBusy = (cyc >= 1 && cyc <= 9);
            expOut  = (cyc == 10);
            checks++;
            if (busy !== expBusy || outEn !== expOut) begin
                errors++;
                $display("FAIL latency_c%0d: busy=%b outEn=%b expected busy=%b outEn=%b",
                         cyc, busy, outEn, expBusy, expOut);
            end
            tick();
            clkEn = 1'b0;
            iIn   = '0;
        end
    endtask

    task automatic test_impulse();
        int lat;
        int oi;
        int oq;
        doReset();
        setImpulseCoefs();
        for (int s = 0; s < 16; s++) begin
            sendSample((s == 0) ? 32768 : 0, 0, lat, oi, oq);
            checks++;
            if (lat !== 10 || oi !== impR[s] || oq !== 0) begin
                errors++;
                $display("FAIL impulse_s%0d: lat=%0d i=%0d q=%0d expected lat=10 i=%0d q=0",
                         s, lat, oi, oq, impR[s]);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL impulse_spacing_overrun: got %b expected 0", overrun);
        end
    endtask

    task automatic test_saturation();
        int lat;
        int oi;
        int oq;
        doReset();
        for (int k = 0; k < 8; k++) coef[k] = 16'sh7FFF;
        oi = 0;
        oq = 0;
        for (int s = 0; s < 15; s++) sendSample(131071, -131072, lat, oi, oq);
        checks++;
        if (oi !== 131071 || oq !== -131072) begin
            errors++;
            $display("FAIL saturation: i=%0d q=%0d expected i=131071 q=-131072", oi, oq);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (iOut !== 18'sd131071 || qOut !== -18'sd131072 || outEn !== 1'b0) begin
            errors++;
            $display("FAIL saturation_hold: i=%0d q=%0d outEn=%b expected 131071 -131072 0",
                     iOut, qOut, outEn);
        end
    endtask

    task automatic test_overrun();
        int lat;
        int oi;
        int oq;
        int nOut;
        doReset();
        setImpulseCoefs();
        iIn   = 18'sd32768;
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        iIn   = '0;
        tick();
        tick();
        tick();
        iIn   = 18'sd5000;
        qIn   = 18'sd777;
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        iIn   = '0;
        qIn   = '0;
        nOut  = 0;
        oi    = -1;
        oq    = -1;
        for (int cyc = 5; cyc < 25; cyc++) begin
            if (outEn === 1'b1) begin
                nOut++;
                oi = int'(iOut);
                oq = int'(qOut);
            end
            tick();
        end
        checks++;
        if (nOut !== 1 || oi !== 49 || oq !== 0) begin
            errors++;
            $display("FAIL overrun_inflight: outEn count=%0d i=%0d q=%0d expected 1 49 0",
                     nOut, oi, oq);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b expected 1", overrun);
        end
        sendSample(0, 0, lat, oi, oq);
        checks++;
        if (oi !== 157 || oq !== 0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_dropped: i=%0d q=%0d overrun=%b expected 157 0 1",
                     oi, oq, overrun);
        end
    endtask

    task automatic test_coef_snapshot();
        int lat;
        int oi;
        int oq;
        doReset();
        setImpulseCoefs();
        sendSample(32768, 0, lat, oi, oq);
        sendSample(0, 32768, lat, oi, oq);
        for (int s = 0; s < 5; s++) sendSample(0, 0, lat, oi, oq);
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        tick();
        tick();
        coef[7] = '0;
        lat = 3;
        while (outEn !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 10 || iOut !== 18'sd12311 || qOut !== 18'sd9221) begin
            errors++;
            $display("FAIL snapshot_inflight: lat=%0d i=%0d q=%0d expected 10 12311 9221",
                     lat, iOut, qOut);
        end
        sendSample(0, 0, lat, oi, oq);
        checks++;
        if (oi !== 9221 || oq !== 0) begin
            errors++;
            $display("FAIL snapshot_next: i=%0d q=%0d expected 9221 0", oi, oq);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int oi;
        int oq;
        int nOut;
        doReset();
        setImpulseCoefs();
        sendSample(32768, 32768, lat, oi, oq);
        iIn   = 18'sd1000;
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        iIn   = '0;
        tick();
        clkEn = 1'b1;
        tick();
        clkEn = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (iOut !== 18'sd0 || qOut !== 18'sd0 || busy !== 1'b0 ||
            overrun !== 1'b0 || outEn !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: i=%0d q=%0d busy=%b overrun=%b outEn=%b expected all 0",
                     iOut, qOut, busy, overrun, outEn);
        end
        nOut = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (outEn === 1'b1) nOut++;
            tick();
        end
        checks++;
        if (nOut !== 0) begin
            errors++;
            $display("FAIL midreset_no_out: outEn count=%0d expected 0", nOut);
        end
        sendSample(32768, -32768, lat, oi, oq);
        checks++;
        if (lat !== 10 || oi !== 49 || oq !== -49) begin
            errors++;
            $display("FAIL midreset_next: lat=%0d i=%0d q=%0d expected 10 49 -49",
                     lat, oi, oq);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) coef[k] = '0;
        test_reset();
        test_latency();
        test_impulse();
        test_saturation();
        test_overrun();
        test_coef_snapshot();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
